// File: rtl/yolo_params_pkg.sv
// Shared parameters and the loader state type for the cnn_top front-end.
package yolo_params_pkg;
    localparam int IP_DATA_WIDTH = 8;
    localparam int IFMAP_SIZE    = 8;
    localparam int FILTER_SIZE   = 3;
    localparam int IMG_BEATS     = IFMAP_SIZE * IFMAP_SIZE;
    localparam int FLT_BEATS     = FILTER_SIZE * FILTER_SIZE;

    typedef enum logic [1:0] {IDLE, LOAD_IMG, LOAD_FLT, HOLD} loader_state_t;
endpackage

// File: rtl/cnn_frame_loader_if.sv
// Valid/ready beat stream feeding the frame loader.
interface cnn_frame_loader_if #(parameter int W = 8);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;

    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/cnn_rc_counter.sv
// Row/column walker over a SIDE x SIDE array; wraps to (0,0) after the last element.
module cnn_rc_counter #(
    parameter  int SIDE = 8,
    localparam int CW   = (SIDE > 1) ? $clog2(SIDE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          at_end_o
);
    localparam logic [CW-1:0] LAST = CW'(SIDE - 1);

    logic [CW-1:0] row_q, col_q;

    assign row_o    = row_q;
    assign col_o    = col_q;
    assign at_end_o = (row_q == LAST) && (col_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clr_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (inc_i) begin
            if (col_q == LAST) begin
                col_q <= '0;
                row_q <= (row_q == LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/cnn_frame_loader.sv
// Assembles a streamed image + filter into parallel arrays and holds them until released.
module cnn_frame_loader
    import yolo_params_pkg::*;
#(
    parameter int IP_DATA_WIDTH = yolo_params_pkg::IP_DATA_WIDTH,
    parameter int IFMAP_SIZE    = yolo_params_pkg::IFMAP_SIZE,
    parameter int FILTER_SIZE   = yolo_params_pkg::FILTER_SIZE
) (
    input  logic clk,
    input  logic rst,
    cnn_frame_loader_if.slave s,
    output logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0]   ifmap,
    output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] filter,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);
    localparam int IW = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
    localparam int FW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;

    loader_state_t state_q, state_d;
    logic          start_q;
    logic          err_q;
    logic [7:0]    cnt_q;
    logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0]   ifmap_q;
    logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] filter_q;

    logic          acc, img_inc, flt_inc, fin_beat, err;
    logic          img_end, flt_end;
    logic [IW-1:0] img_row, img_col;
    logic [FW-1:0] flt_row, flt_col;

    assign s.s_ready = (state_q == LOAD_IMG) || (state_q == LOAD_FLT);
    assign acc       = s.s_valid && s.s_ready;
    assign img_inc   = acc && (state_q == LOAD_IMG);
    assign flt_inc   = acc && (state_q == LOAD_FLT);
    assign fin_beat  = flt_inc && flt_end;
    // s_last must coincide exactly with the final filter beat
    assign err       = acc && (fin_beat ? !s.s_last : s.s_last);

    cnn_rc_counter #(.SIDE(IFMAP_SIZE)) u_img_cnt (
        .clk(clk), .rst(rst), .clr_i(err), .inc_i(img_inc),
        .row_o(img_row), .col_o(img_col), .at_end_o(img_end)
    );

    cnn_rc_counter #(.SIDE(FILTER_SIZE)) u_flt_cnt (
        .clk(clk), .rst(rst), .clr_i(err), .inc_i(flt_inc),
        .row_o(flt_row), .col_o(flt_col), .at_end_o(flt_end)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start_q) state_d = LOAD_IMG;
            LOAD_IMG: begin
                if (err)                     state_d = LOAD_IMG;
                else if (img_inc && img_end) state_d = LOAD_FLT;
            end
            LOAD_FLT: begin
                if (err)           state_d = LOAD_IMG;
                else if (fin_beat) state_d = HOLD;
            end
            HOLD:     if (frame_ready) state_d = LOAD_IMG;
            default:  state_d = IDLE;
        endcase
    end

    // start_q gives one full IDLE cycle after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= 1'b1;
            err_q   <= err;
            if (fin_beat && !err) cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifmap_q  <= '0;
            filter_q <= '0;
        end else begin
            if (img_inc) ifmap_q[img_row][img_col]  <= s.s_data;
            if (flt_inc) filter_q[flt_row][flt_col] <= s.s_data;
        end
    end

    assign ifmap       = ifmap_q;
    assign filter      = filter_q;
    assign frame_valid = (state_q == HOLD);
    assign frame_err   = err_q;
    assign frame_cnt   = cnt_q;
endmodule

// File: tb/tb_cnn_frame_loader.sv
// Directed bench for cnn_frame_loader: load, backpressure, gaps, framing errors, reset.
module tb_cnn_frame_loader;
    import yolo_params_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_ready = 1'b0;
    logic [7:0][7:0][7:0] ifmap;
    logic [2:0][2:0][7:0] filter;
    logic       frame_valid, frame_err;
    logic [7:0] frame_cnt;
    int nchk = 0, nerr = 0;

    always #5 clk = ~clk;

    cnn_frame_loader_if #(.W(8)) s_if ();

    cnn_frame_loader dut (
        .clk(clk), .rst(rst), .s(s_if),
        .ifmap(ifmap), .filter(filter),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the beat is accepted.
    task automatic send(input logic [7:0] d, input logic l, input bit gaps);
        int guard = 0;
        if (gaps && $urandom_range(1, 0) == 1) begin
            s_if.s_valid = 1'b0;
            @(negedge clk);
        end
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        s_if.s_last  = l;
        while (!s_if.s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("ready_timeout", 0, 1);
        @(negedge clk);
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int mul, input bit gaps, input bit good_last);
        for (int i = 0; i < 73; i++) begin
            if (i == 72) chk("fv_before_last", frame_valid, 0);
            send(8'(i * mul), good_last && (i == 72), gaps);
        end
    endtask

    task automatic release_frame();
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        s_if.s_last  = 1'b0;

        // reset values
        #2 rst = 1'b0;
        #1;
        chk("rst_s_ready", s_if.s_ready, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_ifmap77", ifmap[7][7], 0);
        chk("rst_filter22", filter[2][2], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cycle_ready", s_if.s_ready, 0);
        @(negedge clk);
        chk("load_ready", s_if.s_ready, 1);

        // default gapless load
        send_frame(1, 0, 1);
        chk("load_fv", frame_valid, 1);
        chk("load_ready_low", s_if.s_ready, 0);
        chk("load_ifmap23", ifmap[2][3], 19);
        chk("load_ifmap77", ifmap[7][7], 63);
        chk("load_filter12", filter[1][2], 69);
        chk("load_cnt", frame_cnt, 1);

        // backpressure: beats offered while held
        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'hAA;
        repeat (20) begin
            @(negedge clk);
            chk("bp_ready", s_if.s_ready, 0);
            chk("bp_fv", frame_valid, 1);
            chk("bp_ifmap00", ifmap[0][0], 0);
            chk("bp_filter22", filter[2][2], 72);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        s_if.s_valid = 1'b0;
        frame_ready  = 1'b0;
        chk("rel_fv", frame_valid, 0);
        chk("rel_ready", s_if.s_ready, 1);
        chk("rel_ifmap77", ifmap[7][7], 63);

        // random valid gaps, two frames from reset
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        send_frame(1, 1, 1);
        chk("gap1_fv", frame_valid, 1);
        release_frame();
        send_frame(1, 1, 1);
        chk("gap2_fv", frame_valid, 1);
        chk("gap_ifmap01", ifmap[0][1], 1);
        chk("gap_ifmap23", ifmap[2][3], 19);
        chk("gap_ifmap77", ifmap[7][7], 63);
        chk("gap_filter12", filter[1][2], 69);
        chk("gap_filter22", filter[2][2], 72);
        chk("gap_cnt", frame_cnt, 2);
        release_frame();

        // early s_last on beat 10
        for (int i = 0; i < 11; i++) send(8'(8'h80 + i), i == 10, 0);
        chk("early_err", frame_err, 1);
        chk("early_fv", frame_valid, 0);
        chk("early_cnt", frame_cnt, 2);
        chk("early_partial", ifmap[1][2], 8'h8A);
        chk("early_old", ifmap[2][3], 19);
        @(negedge clk);
        chk("early_err_pulse", frame_err, 0);
        send_frame(3, 0, 1);
        chk("reload_fv", frame_valid, 1);
        chk("reload_ifmap23", ifmap[2][3], 57);
        chk("reload_ifmap77", ifmap[7][7], 189);
        chk("reload_filter00", filter[0][0], 192);
        chk("reload_filter12", filter[1][2], 207);
        chk("reload_cnt", frame_cnt, 3);
        release_frame();

        // missing s_last on the final beat
        send_frame(5, 0, 0);
        chk("miss_err", frame_err, 1);
        chk("miss_fv", frame_valid, 0);
        chk("miss_ready", s_if.s_ready, 1);
        chk("miss_state", dut.state_q, LOAD_IMG);
        chk("miss_cnt", frame_cnt, 3);
        chk("miss_filter22", filter[2][2], 104);
        @(negedge clk);
        chk("miss_fv_after", frame_valid, 0);
        chk("miss_err_pulse", frame_err, 0);

        // reset mid-frame at beat 40
        for (int i = 0; i < 40; i++) send(8'h11, 0, 0);
        rst = 1'b0;
        #1;
        chk("mid_ifmap00", ifmap[0][0], 0);
        chk("mid_filter12", filter[1][2], 0);
        chk("mid_cnt", frame_cnt, 0);
        chk("mid_ready", s_if.s_ready, 0);
        chk("mid_fv", frame_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_idle_ready", s_if.s_ready, 0);
        @(negedge clk);
        chk("mid_load_ready", s_if.s_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/cnn_frame_loader.md
# cnn_frame_loader

Streaming front-end for `cnn_top`. It accepts pixels and filter coefficients one beat at a time over a valid/ready stream. It assembles them into the parallel `ifmap` and `filter` arrays that the convolution stage reads. The frame is held stable with `frame_valid` until the downstream controller releases it with `frame_ready`.

## Interface

Parameters:
- `IP_DATA_WIDTH`, default 8: width of one pixel or coefficient.
- `IFMAP_SIZE`, default 8: image side length; the image is `IFMAP_SIZE`×`IFMAP_SIZE`.
- `FILTER_SIZE`, default 3: filter side length.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `s_valid`, in, 1: input beat valid.
- `s_ready`, out, 1: loader can accept a beat.
- `s_data`, in, `IP_DATA_WIDTH`: pixel or coefficient value.
- `s_last`, in, 1: marks the final beat of a frame.
- `ifmap`, out, `[IP_DATA_WIDTH-1:0]` × [IFMAP_SIZE][IFMAP_SIZE]: assembled image.
- `filter`, out, `[IP_DATA_WIDTH-1:0]` × [FILTER_SIZE][FILTER_SIZE]: assembled filter.
- `frame_valid`, out, 1: `ifmap` and `filter` are complete and stable.
- `frame_ready`, in, 1: downstream has consumed the frame.
- `frame_err`, out, 1: one-cycle pulse on a framing error.
- `frame_cnt`, out, 8: count of completed frames, wraps at 255→0.

## Operation

- Beat acceptance: a beat is accepted on a rising edge where `s_valid && s_ready`.
- Frame order:
  - First `IFMAP_SIZE²` beats are pixels, row-major. Beat n writes `ifmap[n/IFMAP_SIZE][n%IFMAP_SIZE]`.
  - Next `FILTER_SIZE²` beats are coefficients, row-major, into `filter`.
  - Default frame length is 73 beats.
- State machine:
  - IDLE: entered on reset; leaves unconditionally to LOAD_IMG on the next cycle.
  - LOAD_IMG: goes to LOAD_FLT on the accepted beat at row = col = IFMAP_SIZE-1.
  - LOAD_FLT: goes to HOLD on the accepted final filter beat with `s_last`=1.
  - HOLD: goes to LOAD_IMG when `frame_ready`=1.
- `s_ready` is 1 in LOAD_IMG and LOAD_FLT, 0 in IDLE and HOLD. It is decoded from the registered state.
- `frame_valid` is 1 exactly in HOLD.
- `frame_cnt` increments on the HOLD entry edge.
- Framing error: either of these on an accepted beat is an error:
  - `s_last`=1 on any beat other than the final filter beat;
  - `s_last`=0 on the final filter beat.
- Error response:
  - `frame_err`=1 for the following cycle.
  - Row/column counters clear and state returns to LOAD_IMG.
  - `frame_cnt` is unchanged and `frame_valid` is not asserted.
  - Array contents keep the partial writes until overwritten.
- Arrays are never cleared except by reset. In LOAD_IMG after HOLD, elements not yet rewritten keep their previous-frame values.
- `frame_ready` is ignored outside HOLD.

## Timing

- Reset values: `s_ready`=0, `frame_valid`=0, `frame_err`=0, `frame_cnt`=0, all `ifmap`/`filter` elements 0, state IDLE.
- After `rst` deasserts: `s_ready` goes to 1 on the second rising edge (one IDLE cycle first).
- Array elements update on the same edge that accepts the beat.
- Latency: `frame_valid` rises one cycle after the final beat is accepted. `s_ready` falls on that same edge, so there is no back-to-back overrun.
- Release: `frame_valid` falls and `s_ready` rises on the edge after `frame_ready` is sampled high in HOLD.
- Throughput: at best one frame per 73 + 1 (HOLD) cycles at default parameters.
- Reset mid-frame: immediate return to reset values. A partial frame is discarded and `frame_cnt` is not incremented.

## Structure

- The shared package `yolo_params_pkg` holds:
  - `IP_DATA_WIDTH`, `IFMAP_SIZE`, `FILTER_SIZE`;
  - derived `IMG_BEATS` and `FLT_BEATS`;
  - `typedef enum logic [1:0] {IDLE, LOAD_IMG, LOAD_FLT, HOLD} loader_state_t`.
- One sub-module, `cnn_rc_counter`:
  - parameterized side length;
  - row/column counter with increment enable, synchronous clear, `at_end` flag and wrap to 0;
  - instantiated once for the image and once for the filter.

## Test plan

- **Default load:** reset, then stream 73 beats with `s_data`=beat index mod 256, `s_last` on beat 72, `s_valid` held high. Expect `ifmap[2][3]`=19, `ifmap[7][7]`=63, `filter[1][2]`=69. Expect `frame_valid` rising exactly one cycle after beat 72, and `frame_cnt`=1.
- **Backpressure:** hold `frame_ready`=0 for 20 cycles while `s_valid`=1. Expect `s_ready`=0, arrays unchanged and `frame_valid` high throughout. Pulse `frame_ready`: `frame_valid`=0 and `s_ready`=1 on the next edge.
- **Random valid gaps:** `s_valid` 50% random over two frames. Expect identical array contents to the gapless case and `frame_cnt`=2.
- **Early `s_last`:** assert `s_last` on beat 10. Expect `frame_err` pulse for one cycle, `frame_cnt` unchanged, and the next 73-beat frame loads correctly.
- **Missing `s_last`:** final beat sent with `s_last`=0. Expect `frame_err`=1, no `frame_valid`, state back to LOAD_IMG.
- **Reset mid-frame:** assert `rst` low at beat 40. Expect all outputs and arrays 0 immediately, and `s_ready`=1 on the second edge after release.
